ram_to_ft245_tx: RTL and testbench

//  Drains one completed ADC capture frame from the dual-port sample RAM (read port B) and streams it to an FT245 USB FIFO.

---
 rtl/ram_to_ft245_tx.sv | 164 ++++++++++++++++
 tb/tb_ram_to_ft245_tx.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_to_ft245_tx.sv
// Streams one ADC capture frame from sample RAM port B to an FT245 USB FIFO, low byte first, paced by TXE#.
// Define FT_SYNC_HEADER_EN to prefix each frame with the sync header bytes 8'hA5, 8'h5A.
module ram_to_ft245_tx #(
    parameter int ADDR_WIDTH = 10,
    parameter int WR_SETUP   = 2,
    parameter int WR_PULSE   = 4,
    parameter int WR_RECOVER = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [15:0]           ram_data_in,
    input  logic                  ft_txe_n,
    output logic                  ft_wr,
    output logic [7:0]            ft_data,
    output logic                  ft_data_oe,
    output logic                  busy,
    output logic                  done,
    output logic [2:0]            fsm_state
);
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] FETCH    = 3'd1;
    localparam logic [2:0] WAIT_TXE = 3'd2;
    localparam logic [2:0] SETUP    = 3'd3;
    localparam logic [2:0] STROBE   = 3'd4;
    localparam logic [2:0] RECOVER  = 3'd5;
    localparam logic [2:0] FINISH   = 3'd6;

    localparam int CW = 16;

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [15:0]   word;
    logic          byte_hi;
    logic          txe_s1;
    logic          txe_s2;
`ifdef FT_SYNC_HEADER_EN
    logic          hdr;
`endif

    assign fsm_state = state;

    // Data bus follows the latched word and byte index, so it only moves when those registers do.
    always_comb begin
        ft_data = byte_hi ? word[15:8] : word[7:0];
`ifdef FT_SYNC_HEADER_EN
        if (hdr) ft_data = byte_hi ? 8'h5A : 8'hA5;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            word        <= '0;
            byte_hi     <= 1'b0;
            txe_s1      <= 1'b1;
            txe_s2      <= 1'b1;
            ram_rd_addr <= '0;
            ft_wr       <= 1'b0;
            ft_data_oe  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
`ifdef FT_SYNC_HEADER_EN
            hdr         <= 1'b0;
`endif
        end else begin
            txe_s1 <= ft_txe_n;
            txe_s2 <= txe_s1;
            done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy        <= 1'b1;
                        ram_rd_addr <= '0;
                        cnt         <= '0;
`ifdef FT_SYNC_HEADER_EN
                        hdr         <= 1'b1;
                        byte_hi     <= 1'b0;
                        ft_data_oe  <= 1'b1;
                        state       <= WAIT_TXE;
`else
                        state       <= FETCH;
`endif
                    end
                end
                // Two cycles: one for the address register, one for the RAM read latency.
                FETCH: begin
                    if (cnt == CW'(1)) begin
                        cnt        <= '0;
                        word       <= ram_data_in;
                        byte_hi    <= 1'b0;
                        ft_data_oe <= 1'b1;
                        state      <= WAIT_TXE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                WAIT_TXE: begin
                    if (!txe_s2) begin
                        cnt   <= '0;
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt == CW'(WR_SETUP - 1)) begin
                        cnt   <= '0;
                        ft_wr <= 1'b1;
                        state <= STROBE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                STROBE: begin
                    if (cnt == CW'(WR_PULSE - 1)) begin
                        cnt   <= '0;
                        ft_wr <= 1'b0;
                        state <= RECOVER;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RECOVER: begin
                    if (cnt == CW'(WR_RECOVER - 1)) begin
                        cnt <= '0;
`ifdef FT_SYNC_HEADER_EN
                        if (hdr) begin
                            if (!byte_hi) begin
                                byte_hi <= 1'b1;
                                state   <= WAIT_TXE;
                            end else begin
                                hdr   <= 1'b0;
                                state <= FETCH;
                            end
                        end else
`endif
                        if (!byte_hi) begin
                            byte_hi <= 1'b1;
                            state   <= WAIT_TXE;
                        end else if (ram_rd_addr != '1) begin
                            ram_rd_addr <= ram_rd_addr + ADDR_WIDTH'(1);
                            state       <= FETCH;
                        end else begin
                            done        <= 1'b1;
                            busy        <= 1'b0;
                            ft_data_oe  <= 1'b0;
                            ram_rd_addr <= '0;
                            state       <= FINISH;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ram_to_ft245_tx.sv
// Directed bench for ram_to_ft245_tx: byte order, strobe timing, TXE# stall, mid-frame reset, ignored START.
// Honours FT_SYNC_HEADER_EN so the expected stream matches the build.
module tb_ram_to_ft245_tx;
    localparam int AW        = 2;
    localparam int SETUP_C   = 2;
    localparam int PULSE_C   = 4;
    localparam int RECOVER_C = 2;
`ifdef FT_SYNC_HEADER_EN
    localparam int HDR = 2;
`else
    localparam int HDR = 0;
`endif
    localparam int NBYTES = 8 + HDR;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WAIT_TXE = 3'd2;
    localparam logic [2:0] S_SETUP    = 3'd3;

    logic          clk;
    logic          rst;
    logic          start;
    logic [AW-1:0] ram_rd_addr;
    logic [15:0]   ram_data_in;
    logic          ft_txe_n;
    logic          ft_wr;
    logic [7:0]    ft_data;
    logic          ft_data_oe;
    logic          busy;
    logic          done;
    logic [2:0]    fsm_state;

    logic [15:0] ram [0:3];

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    int         rise_cnt   = 0;
    int         fall_cnt   = 0;
    int         done_cnt   = 0;
    int         high_len   = 0;
    int         stable_run = 0;
    logic       wr_prev    = 1'b0;
    logic       after_fall = 1'b0;
    logic [7:0] data_prev  = 8'h00;
    logic [7:0] pulse_data = 8'h00;

    ram_to_ft245_tx #(
        .ADDR_WIDTH (AW),
        .WR_SETUP   (SETUP_C),
        .WR_PULSE   (PULSE_C),
        .WR_RECOVER (RECOVER_C)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .ram_rd_addr (ram_rd_addr),
        .ram_data_in (ram_data_in),
        .ft_txe_n    (ft_txe_n),
        .ft_wr       (ft_wr),
        .ft_data     (ft_data),
        .ft_data_oe  (ft_data_oe),
        .busy        (busy),
        .done        (done),
        .fsm_state   (fsm_state)
    );

    // Clock and reset-time defaults
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read RAM: data appears one clock after the address.
    always @(posedge clk) ram_data_in <= ram[ram_rd_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bus monitor on the falling edge: captures bytes and checks strobe shape.
    always @(negedge clk) begin
        if (rst) begin
            wr_prev    = 1'b0;
            high_len   = 0;
            stable_run = 0;
            after_fall = 1'b0;
        end else begin
            if (after_fall) begin
                check("data_hold_after_fall", ft_data, pulse_data);
                after_fall = 1'b0;
            end
            if (ft_data_oe && ft_data == data_prev) stable_run++;
            else stable_run = 1;
            if (ft_wr && !wr_prev) begin
                rise_cnt++;
                pulse_data = ft_data;
                got_q.push_back(ft_data);
                high_len = 1;
                check("setup_stable", 32'(stable_run >= SETUP_C + 1), 1);
                check("oe_at_rise", ft_data_oe, 1);
            end else if (ft_wr) begin
                high_len++;
            end
            if (!ft_wr && wr_prev) begin
                fall_cnt++;
                check("pulse_width", high_len, PULSE_C);
                check("data_hold_at_fall", ft_data, pulse_data);
                after_fall = 1'b1;
            end
            if (done) done_cnt++;
            wr_prev   = ft_wr;
            data_prev = ft_data;
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic reset_mon();
        rise_cnt = 0;
        fall_cnt = 0;
        done_cnt = 0;
        got_q.delete();
    endtask

    task automatic load_exp();
        exp_q.delete();
`ifdef FT_SYNC_HEADER_EN
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
`endif
        exp_q.push_back(8'h34); exp_q.push_back(8'h12);
        exp_q.push_back(8'hCD); exp_q.push_back(8'hAB);
        exp_q.push_back(8'h0F); exp_q.push_back(8'h0F);
        exp_q.push_back(8'hFF); exp_q.push_back(8'hFF);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done_cnt < 1 && n < 2000) begin
            tick();
            n++;
        end
        check({tag, "_done_seen"}, 32'(done_cnt >= 1), 1);
    endtask

    task automatic compare_stream(input string tag);
        check({tag, "_byte_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) check($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
        end
    endtask

    initial begin
        int n;
        ram[0] = 16'h1234;
        ram[1] = 16'hABCD;
        ram[2] = 16'h0F0F;
        ram[3] = 16'hFFFF;
        rst = 1'b1;
        start = 1'b0;
        ft_txe_n = 1'b1;
        load_exp();
        repeat (3) tick();

        check("rst_ft_wr", ft_wr, 0);
        check("rst_ft_data", ft_data, 8'h00);
        check("rst_oe", ft_data_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_addr", ram_rd_addr, 0);
        check("rst_state", fsm_state, S_IDLE);
        rst = 1'b0;
        repeat (2) tick();

        // Basic frame with the FIFO always ready
        ft_txe_n = 1'b0;
        repeat (3) tick();
        reset_mon();
        pulse_start();
        check("t1_busy_after_start", busy, 1);
        wait_done("t1");
        check("t1_wr_rises", rise_cnt, NBYTES);
        check("t1_wr_falls", fall_cnt, NBYTES);
        check("t1_busy_after_done", busy, 0);
        tick();
        check("t1_done_pulses", done_cnt, 1);
        check("t1_done_low", done, 0);
        check("t1_oe_low", ft_data_oe, 0);
        compare_stream("t1");
        repeat (5) tick();

        // TXE# stall before byte 3, plus a redundant START while busy
        reset_mon();
        pulse_start();
        n = 0;
        while (rise_cnt < HDR + 2 && n < 500) begin tick(); n++; end
        check("t3_reached_byte2", 32'(rise_cnt >= HDR + 2), 1);
        ft_txe_n = 1'b1;
        n = 0;
        while (fsm_state != S_WAIT_TXE && n < 50) begin tick(); n++; end
        check("t3_parked", fsm_state, S_WAIT_TXE);
        for (int i = 0; i < 50; i++) begin
            if (i == 10) start = 1'b1;
            tick();
            start = 1'b0;
        end
        check("t3_still_waiting", fsm_state, S_WAIT_TXE);
        check("t3_wr_low", ft_wr, 0);
        check("t3_no_extra_byte", rise_cnt, HDR + 2);
        check("t5_busy_held", busy, 1);
        ft_txe_n = 1'b0;
        n = 0;
        while (fsm_state != S_SETUP && n < 10) begin tick(); n++; end
        check("t3_release_latency", n, 3);
        wait_done("t3");
        tick();
        check("t5_wr_rises", rise_cnt, NBYTES);
        check("t5_done_pulses", done_cnt, 1);
        compare_stream("t3");
        repeat (5) tick();

        // Reset mid-strobe of byte 5, then a fresh frame
        reset_mon();
        pulse_start();
        n = 0;
        while (rise_cnt < HDR + 5 && n < 500) begin tick(); n++; end
        check("t4_strobe_active", ft_wr, 1);
        rst = 1'b1;
        #1;
        check("t4_rst_ft_wr", ft_wr, 0);
        check("t4_rst_oe", ft_data_oe, 0);
        check("t4_rst_busy", busy, 0);
        check("t4_rst_addr", ram_rd_addr, 0);
        check("t4_rst_state", fsm_state, S_IDLE);
        tick();
        rst = 1'b0;
        repeat (3) tick();
        reset_mon();
        pulse_start();
        wait_done("t4");
        tick();
        check("t4_wr_rises", rise_cnt, NBYTES);
        check("t4_done_pulses", done_cnt, 1);
        compare_stream("t4");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end
endmodule
